uart_tx_serializer: RTL and testbench

UART transmit stage that sits directly downstream of the baud generator. It consumes the generator's square-wave baud output as its bit-rate reference and serialises one parallel byte per request into a standard asynchronous frame on tx. The frame is start bit, data bits LSB first, optional parity, then stop bit(s). A simple start/busy/done handshake connects it to the host logic.

---
 rtl/uart_tx_serializer.sv | 139 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: turns one parallel word per request into an
// asynchronous frame (start, data LSB first, optional parity, stop bits),
// pacing every bit from rising edges of the baud generator's square wave.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 baud_in,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic       PAR_ODD   = (PARITY_ODD != 0);
   localparam logic       PAR_ON    = (PARITY_EN != 0);

   state_t               state, state_nxt;
   logic                 baud_q;
   logic                 tick;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic                 par, par_nxt;
   logic                 tx_nxt, busy_nxt, done_nxt;

   // One-cycle pulse on each rising edge of the baud square wave.
   assign tick = baud_in & ~baud_q;

   // Delay the baud wave by one clock for edge detection.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) baud_q <= 1'b0;
      else      baud_q <= baud_in;
   end

   // State, datapath and registered line outputs.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         shift_reg <= '0;
         cnt       <= '0;
         par       <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         cnt       <= cnt_nxt;
         par       <= par_nxt;
         tx        <= tx_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Next-state, datapath update and the line level for the state being entered.
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      cnt_nxt   = cnt;
      par_nxt   = par;
      done_nxt  = 1'b0;

      case (state)
         S_IDLE: begin
            // A tick coinciding with acceptance is dropped: ALIGN waits for the next one,
            // so the start bit always spans a full baud period.
            if (tx_start) begin
               shift_nxt = tx_data;
               cnt_nxt   = '0;
               par_nxt   = 1'b0;
               state_nxt = S_ALIGN;
            end
         end
         S_ALIGN: begin
            if (tick) state_nxt = S_START;
         end
         S_START: begin
            if (tick) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (tick) begin
               par_nxt   = par ^ shift_reg[0];
               shift_nxt = shift_reg >> 1;
               if (cnt == LAST_DATA) begin
                  cnt_nxt   = '0;
                  state_nxt = PAR_ON ? S_PARITY : S_STOP;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               cnt_nxt   = '0;
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (cnt == LAST_STOP) begin
                  cnt_nxt   = '0;
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      case (state_nxt)
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = shift_nxt[0];
         S_PARITY: tx_nxt = par_nxt ^ PAR_ODD;
         default:  tx_nxt = 1'b1;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations share clock, reset, baud
// and start; a frame-level model predicts every output each cycle, and
// mid-bit line captures are compared against hand-computed frames.
module tb_uart_tx_serializer;

   localparam int HALF = 4;

   logic       clock = 1'b0;
   logic       rst;
   logic       baud_in = 1'b0;
   logic       tx_start;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic [2:0] tx_w, busy_w, done_w;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .clock(clock), .rst(rst), .baud_in(baud_in), .tx_start(tx_start), .tx_data(d0),
      .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
      .clock(clock), .rst(rst), .baud_in(baud_in), .tx_start(tx_start), .tx_data(d1),
      .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   uart_tx_serializer #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
      .clock(clock), .rst(rst), .baud_in(baud_in), .tx_start(tx_start), .tx_data(d2),
      .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   // Baud wave: toggles every HALF clocks while running; b_rose flags a fresh rise.
   bit baud_run = 1'b1;
   bit b_rose   = 1'b0;
   int bcnt     = 0;
   always @(posedge clock) begin
      #1;
      b_rose = 1'b0;
      if (baud_run) begin
         if (bcnt == HALF - 1) begin
            bcnt    = 0;
            baud_in = ~baud_in;
            b_rose  = baud_in;
         end else begin
            bcnt++;
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   function automatic int cfg_db(int i); return (i == 2) ? 7 : 8; endfunction
   function automatic bit cfg_pe(int i); return (i != 2);          endfunction
   function automatic bit cfg_po(int i); return (i == 1);          endfunction
   function automatic int cfg_sb(int i); return (i == 2) ? 2 : 1;  endfunction

   bit m_idle  [3];
   bit m_done  [3];
   int m_phase [3];
   int m_len   [3];
   bit m_frame [3][16];
   bit m_bq;

   function automatic logic [7:0] data_of(int i);
      case (i)
         0:       return d0;
         1:       return d1;
         default: return {1'b0, d2};
      endcase
   endfunction

   // Frame = start 0, data LSB first, optional parity, stop 1s.
   function automatic void build(int i);
      logic [7:0] dv;
      bit         p;
      int         n;
      dv = data_of(i);
      p  = cfg_po(i);
      n  = 0;
      m_frame[i][n++] = 1'b0;
      for (int b = 0; b < cfg_db(i); b++) begin
         m_frame[i][n++] = dv[b];
         p = p ^ dv[b];
      end
      if (cfg_pe(i)) m_frame[i][n++] = p;
      for (int s = 0; s < cfg_sb(i); s++) m_frame[i][n++] = 1'b1;
      m_len[i] = n;
   endfunction

   // Phase -1 is the wait for the first tick; phases 0..len-1 index the frame.
   always @(posedge clock or negedge rst) begin
      bit tk;
      if (!rst) begin
         m_bq = 1'b0;
         for (int i = 0; i < 3; i++) begin
            m_idle[i]  = 1'b1;
            m_done[i]  = 1'b0;
            m_phase[i] = -1;
         end
      end else begin
         tk   = baud_in & ~m_bq;
         m_bq = baud_in;
         for (int i = 0; i < 3; i++) begin
            m_done[i] = 1'b0;
            if (m_idle[i]) begin
               if (tx_start) begin
                  build(i);
                  m_idle[i]  = 1'b0;
                  m_phase[i] = -1;
               end
            end else if (tk) begin
               m_phase[i]++;
               if (m_phase[i] == m_len[i]) begin
                  m_idle[i] = 1'b1;
                  m_done[i] = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all three DUTs against the model.
   always @(negedge clock) begin
      logic et;
      for (int i = 0; i < 3; i++) begin
         if (m_idle[i] || m_phase[i] < 0) et = 1'b1;
         else                             et = m_frame[i][m_phase[i]];
         check($sformatf("line_dut%0d {tx,busy,done}", i),
               {29'b0, tx_w[i], busy_w[i], done_w[i]},
               {29'b0, et, ~m_idle[i], m_done[i]});
      end
   end

   // ---------------- mid-bit capture for literal frame checks ----------------
   bit          cap_on  [3];
   bit          cap_st  [3];
   logic [15:0] cap_vec [3];
   int          cap_n   [3];
   int          cap_len [3];
   logic        last_bn = 1'b0;

   always @(negedge clock) begin
      if (!baud_in && last_bn) begin
         for (int i = 0; i < 3; i++) begin
            if (cap_on[i]) begin
               if (!cap_st[i] && tx_w[i] == 1'b0) cap_st[i] = 1'b1;
               if (cap_st[i]) begin
                  cap_vec[i][cap_n[i]] = tx_w[i];
                  cap_n[i]++;
                  if (cap_n[i] >= cap_len[i]) cap_on[i] = 1'b0;
               end
            end
         end
      end
      last_bn = baud_in;
   end

   task automatic arm(int i, int len);
      cap_on[i]  = 1'b1;
      cap_st[i]  = 1'b0;
      cap_vec[i] = '0;
      cap_n[i]   = 0;
      cap_len[i] = len;
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic pulse_start();
      tx_start = 1'b1;
      step(1);
      tx_start = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int k = 0;
      while (busy_w != 3'b000 && k < 600) begin
         step(1);
         k++;
      end
      if (k >= 600) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout busy=%b required=000", name, busy_w);
      end
      step(2);
   endtask

   task automatic frame_check(string name, int i, logic [15:0] vec, int len);
      check({name, "_bits"}, {16'b0, cap_vec[i]}, {16'b0, vec});
      check({name, "_len"}, cap_n[i], len);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst      = 1'b0;
      tx_start = 1'b0;
      d0 = '0; d1 = '0; d2 = '0;
      for (int i = 0; i < 3; i++) cap_on[i] = 1'b0;
      step(3);
      check("reset_tx",   {29'b0, tx_w},   32'h7);
      check("reset_busy", {29'b0, busy_w}, 32'h0);
      check("reset_done", {29'b0, done_w}, 32'h0);
      rst = 1'b1;
      step(5);

      // Basic frames, plus a mid-frame request and data change that must be ignored.
      d0 = 8'hA5; d1 = 8'h07; d2 = 7'h55;
      arm(0, 11); arm(1, 11); arm(2, 10);
      pulse_start();
      check("busy_after_accept", {29'b0, busy_w}, 32'h7);
      step(40);
      d0 = 8'hFF; d1 = 8'hFF; d2 = 7'h7F;
      pulse_start();
      wait_idle("basic");
      frame_check("a5_even",   0, 16'h054A, 11);
      frame_check("07_odd",    1, 16'h040E, 11);
      frame_check("55_7n2",    2, 16'h03AA, 10);

      // Parity flips: 07 even, A5 odd.
      d0 = 8'h07; d1 = 8'hA5; d2 = 7'h12;
      arm(0, 11); arm(1, 11);
      pulse_start();
      wait_idle("parity");
      frame_check("07_even", 0, 16'h060E, 11);
      frame_check("a5_odd",  1, 16'h074A, 11);

      // Back-to-back: new request in the done cycle.
      d0 = 8'h3C;
      arm(0, 11);
      pulse_start();
      k = 0;
      while (!done_w[0] && k < 300) begin step(1); k++; end
      check("done_seen", {31'b0, done_w[0]}, 32'h1);
      frame_check("3c_first", 0, 16'h0478, 11);
      d0 = 8'h81;
      arm(0, 11);
      pulse_start();
      wait_idle("b2b");
      frame_check("81_b2b", 0, 16'h0502, 11);

      // Acceptance coinciding with a tick: start bit still a full period.
      d0 = 8'hA5;
      k = 0;
      while (!b_rose && k < 20) begin step(1); k++; end
      pulse_start();
      k = 0;
      while (tx_w[0] && k < 40) begin step(1); k++; end
      k = 0;
      while (!tx_w[0] && k < 40) begin step(1); k++; end
      check("start_len_on_tick", k, 8);
      wait_idle("collision");

      // Reset during data bit 3, then a fresh frame.
      d0 = 8'hA5;
      pulse_start();
      k = 0;
      while (m_phase[0] != 4 && k < 200) begin step(1); k++; end
      step(2);
      rst = 1'b0;
      #1;
      check("midreset_tx",   {29'b0, tx_w},   32'h7);
      check("midreset_busy", {29'b0, busy_w}, 32'h0);
      step(3);
      rst = 1'b1;
      step(2);
      d0 = 8'h12;
      arm(0, 11);
      pulse_start();
      wait_idle("after_reset");
      frame_check("12_after_reset", 0, 16'h0424, 11);

      // Randomized requests, data and baud stalls.
      for (int it = 0; it < 40; it++) begin
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         d2 = 7'($urandom);
         pulse_start();
         step($urandom_range(1, 60));
         d0 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            baud_run = 1'b0;
            step($urandom_range(5, 40));
            baud_run = 1'b1;
         end
         if ($urandom_range(0, 2) == 0) pulse_start();
         step($urandom_range(1, 80));
      end
      wait_idle("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
